// File: rtl/seven_seg_scan_driver_if.sv
// Pin bundle between the stopwatch counter chain (master) and the
// seven-segment scan driver (slave), plus the driver's scan-position debug view.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // There is no valid/ready pair. digits, blank_mask and dp_in are level
  // signals sampled by the driver on every clk edge. seg, dp, an and scan_tick
  // are registered and always meaningful. scan_tick is a strobe that needs no
  // acknowledge.
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    scan_tick;
  logic [IDX_W-1:0]        scan_idx;

  modport master (
    output digits, blank_mask, dp_in,
    input  seg, dp, an, scan_tick, scan_idx
  );

  modport slave (
    input  digits, blank_mask, dp_in,
    output seg, dp, an, scan_tick, scan_idx
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Round-robin seven-segment scan driver with registered, polarity-selectable pins.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                   clk,
  input  logic                   Reset,
  seven_seg_scan_driver_if.slave bus
);
  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic POL   = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  started_q, started_d;

  logic [3:0]            digit_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_eff;

  logic [6:0]            seg_c;
  logic                  dp_c;
  logic [NUM_DIGITS-1:0] an_c;
  logic                  tick_c;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  tick_q;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_val[k] = bus.digits[4*k +: 4];
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;

  // Digit k is leading if it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      lz[k] = 1'b1;
      for (int j = k; j < NUM_DIGITS; j++) begin
        if (digit_val[j] != 4'd0) lz[k] = 1'b0;
      end
    end
  end

  assign blank_eff = bus.blank_mask | lz;
`else
  assign blank_eff = bus.blank_mask;
`endif

  // State register: scan position plus the output pin registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      div_q     <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
      seg_q     <= {7{POL}};
      dp_q      <= POL;
      an_q      <= {NUM_DIGITS{POL}};
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      seg_q     <= seg_c ^ {7{POL}};
      dp_q      <= dp_c ^ POL;
      an_q      <= an_c ^ {NUM_DIGITS{POL}};
      tick_q    <= tick_c;
    end
  end

  // Next-state: the divider paces the digit index; started marks that a wrap can now occur.
  always_comb begin
    div_d     = div_q + 1'b1;
    idx_d     = idx_q;
    started_d = started_q;
    if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_d     = '0;
      started_d = 1'b1;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_d = '0;
      else                                 idx_d = idx_q + 1'b1;
    end
  end

  // Output decode, active-high; the pin registers above apply the polarity.
  always_comb begin
    an_c        = '0;
    an_c[idx_q] = 1'b1;
    seg_c       = blank_eff[idx_q] ? 7'b0000000 : seg7(digit_val[idx_q]);
    dp_c        = bus.dp_in[idx_q] & ~blank_eff[idx_q];
    // Digit 0 with a fresh divider after at least one advance is the wrap point.
    tick_c      = started_q && (idx_q == '0) && (div_q == '0);
  end

  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.an        = an_q;
  assign bus.scan_tick = tick_q;
  assign bus.scan_idx  = idx_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: position-based reference model checked
// every cycle, plus literal pin expectations for each scenario.
module tb_seven_seg_scan_driver;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int AL = 1;

  logic clk = 1'b0;
  logic Reset = 1'b1;

  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(AL)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the pins must show, from elapsed cycles since reset release.
  logic [6:0] seg_tab [16];

  function automatic logic lead_blank(input int k, input logic [4*ND-1:0] d);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (k == 0) return 1'b0;
    for (int j = k; j < ND; j++) begin
      if (d[4*j +: 4] != 4'd0) return 1'b0;
    end
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  int            rel = 0;
  logic [6:0]    e_seg;
  logic          e_dp;
  logic [ND-1:0] e_an;
  logic          e_tick;

  always @(posedge clk) begin
    int   k;
    logic blk;
    if (Reset) begin
      rel    = 0;
      e_an   = '0;
      e_seg  = '0;
      e_dp   = 1'b0;
      e_tick = 1'b0;
    end else begin
      k      = (rel / RD) % ND;
      blk    = bus.blank_mask[k] | lead_blank(k, bus.digits);
      e_an   = ND'(1) << k;
      e_seg  = blk ? 7'b0000000 : seg_tab[bus.digits[4*k +: 4]];
      e_dp   = bus.dp_in[k] & ~blk;
      e_tick = (rel > 0) && (rel % (RD * ND) == 0);
      rel++;
    end
    if (AL != 0) begin
      e_an  = ~e_an;
      e_seg = ~e_seg;
      e_dp  = ~e_dp;
    end
    #2;
    check("model_an",   32'(bus.an),   32'(e_an));
    check("model_seg",  32'(bus.seg),  32'(e_seg));
    check("model_dp",   32'(bus.dp),   32'(e_dp));
    check("model_tick", 32'(bus.scan_tick), 32'(e_tick));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_an(input logic [ND-1:0] pat, input string name);
    for (int i = 0; i < 40; i++) begin
      if (bus.an === pat) break;
      cyc(1);
    end
    check(name, 32'(bus.an), 32'(pat));
  endtask

  initial begin
    seg_tab[0]  = 7'b0111111; seg_tab[1]  = 7'b0000110;
    seg_tab[2]  = 7'b1011011; seg_tab[3]  = 7'b1001111;
    seg_tab[4]  = 7'b1100110; seg_tab[5]  = 7'b1101101;
    seg_tab[6]  = 7'b1111101; seg_tab[7]  = 7'b0000111;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1101111;
    for (int v = 10; v < 16; v++) seg_tab[v] = 7'b0000000;

    bus.digits     = 16'h1234;
    bus.blank_mask = '0;
    bus.dp_in      = '0;
    Reset          = 1'b1;

    // Reset for two edges, then the first released cycle is still dark.
    cyc(2);
    Reset = 1'b0;
    check("rel_an_off",  32'(bus.an),  32'(4'b1111));
    check("rel_seg_off", 32'(bus.seg), 32'(7'b1111111));
    check("rel_tick",    32'(bus.scan_tick), 0);

    cyc(1);
    check("d0_an",   32'(bus.an),  32'(4'b1110));
    check("d0_seg4", 32'(bus.seg), 32'(7'b0011001));
    check("d0_no_tick_after_reset", 32'(bus.scan_tick), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("d0_hold", 32'(bus.an), 32'(4'b1110));
    end
    cyc(1);
    check("d1_an",   32'(bus.an),  32'(4'b1101));
    check("d1_seg3", 32'(bus.seg), 32'(7'b0110000));
    cyc(3);
    cyc(1);
    check("d2_an",   32'(bus.an),  32'(4'b1011));
    check("d2_seg2", 32'(bus.seg), 32'(7'b0100100));
    cyc(3);
    cyc(1);
    check("d3_an",   32'(bus.an),  32'(4'b0111));
    check("d3_seg1", 32'(bus.seg), 32'(7'b1111001));
    cyc(3);

    // Wrap after 16 cycles: tick for exactly one cycle.
    cyc(1);
    check("wrap_an",   32'(bus.an), 32'(4'b1110));
    check("wrap_tick", 32'(bus.scan_tick), 1);
    cyc(1);
    check("wrap_tick_drop", 32'(bus.scan_tick), 0);

    // Non-BCD, blanking and decimal point.
    bus.digits     = 16'h00A9;
    bus.blank_mask = 4'b0100;
    bus.dp_in      = 4'b0001;
    wait_an(4'b1101, "blk_reach_d1");
    check("blk_d1_nonbcd", 32'(bus.seg), 32'(7'b1111111));
    wait_an(4'b1011, "blk_reach_d2");
    check("blk_d2_seg", 32'(bus.seg), 32'(7'b1111111));
    check("blk_d2_dp",  32'(bus.dp),  1);
    wait_an(4'b0111, "blk_reach_d3");
    check("blk_d3_seg0", 32'(bus.seg), 32'(7'b1000000));
    wait_an(4'b1110, "blk_reach_d0");
    check("blk_d0_seg9", 32'(bus.seg), 32'(7'b0010000));
    check("blk_d0_dp",   32'(bus.dp),  0);

    // Reset mid-scan at idx=2, divider=1.
    wait_an(4'b1011, "rst_reach_d2");
    Reset = 1'b1;
    cyc(1);
    check("mid_rst_an",   32'(bus.an),  32'(4'b1111));
    check("mid_rst_seg",  32'(bus.seg), 32'(7'b1111111));
    check("mid_rst_tick", 32'(bus.scan_tick), 0);
    Reset = 1'b0;
    cyc(1);
    check("restart_an",   32'(bus.an), 32'(4'b1110));
    check("restart_tick", 32'(bus.scan_tick), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("restart_hold", 32'(bus.an), 32'(4'b1110));
    end
    cyc(1);
    check("restart_d1", 32'(bus.an), 32'(4'b1101));

    // Live input change while digit 0 is active.
    bus.digits     = 16'h0000;
    bus.blank_mask = '0;
    bus.dp_in      = '0;
    wait_an(4'b1110, "live_reach_d0");
    check("live_seg_before", 32'(bus.seg), 32'(7'b1000000));
    bus.digits = 16'h0009;
    cyc(1);
    check("live_seg_after", 32'(bus.seg), 32'(7'b0010000));
    check("live_an_same",   32'(bus.an),  32'(4'b1110));

    // Leading-zero handling.
    bus.digits = 16'h0105;
    wait_an(4'b0111, "lz_reach_d3");
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    check("lz_d3_dark", 32'(bus.seg), 32'(7'b1111111));
`else
    check("lz_d3_zero", 32'(bus.seg), 32'(7'b1000000));
`endif
    wait_an(4'b1011, "lz_reach_d2");
    check("lz_d2_one",  32'(bus.seg), 32'(7'b1111001));
    wait_an(4'b1101, "lz_reach_d1");
    check("lz_d1_zero", 32'(bus.seg), 32'(7'b1000000));
    wait_an(4'b1110, "lz_reach_d0");
    check("lz_d0_five", 32'(bus.seg), 32'(7'b0010010));

    // All zeros: digit 0 must still show 0 in either build.
    bus.digits = 16'h0000;
    wait_an(4'b1101, "zero_reach_d1");
    wait_an(4'b1110, "zero_reach_d0");
    check("zero_d0_shows", 32'(bus.seg), 32'(7'b1000000));

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
